// File: rtl/fifo_uart_tx.sv
// FIFO-fed asynchronous serial transmitter: start bit, WIDTH data bits LSB first,
// optional even parity (define UART_TX_PARITY_EN), STOP_BITS stop bits.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,   // must be >= 2
    parameter int STOP_BITS    = 1     // 1 or 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] fifo_q,
    input  logic             fifo_ready,
    output logic             fifo_pop,
    input  logic             cts,
    output logic             txd,
    output logic             busy,
    output logic             done
);

    localparam int DIV_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [CNT_W-1:0] bit_reg, bit_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic             txd_reg, txd_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             pop;
    logic             bit_end;

`ifdef UART_TX_PARITY_EN
    logic parity_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            parity_reg <= 1'b0;
        else if (pop)
            parity_reg <= ^fifo_q;
    end
`endif

    assign bit_end = (div_reg == '0);

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                pop = fifo_ready & cts;
                if (pop) begin
                    shift_next = fifo_q;
                    div_next   = DIV_LOAD;
                    state_next = START;
                end
            end
            START: begin
                div_next = bit_end ? DIV_LOAD : div_reg - DIV_W'(1);
                if (bit_end) begin
                    bit_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                div_next = bit_end ? DIV_LOAD : div_reg - DIV_W'(1);
                if (bit_end) begin
                    if (bit_reg == LAST_DATA) begin
                        bit_next   = '0;
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next   = bit_reg + CNT_W'(1);
                        shift_next = shift_reg >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                div_next = bit_end ? DIV_LOAD : div_reg - DIV_W'(1);
                if (bit_end)
                    state_next = STOP;
            end
`endif
            STOP: begin
                // bit_reg counts stop bits here; the divider stays at 0 on return to IDLE
                if (bit_end) begin
                    if (bit_reg == LAST_STOP) begin
                        bit_next   = '0;
                        state_next = IDLE;
                    end else begin
                        bit_next = bit_reg + CNT_W'(1);
                        div_next = DIV_LOAD;
                    end
                end else begin
                    div_next = div_reg - DIV_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // Registered outputs are decoded from the state being entered.
        txd_next = 1'b1;
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_next = parity_reg;
`endif
            default: txd_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
        done_next = (state_next == STOP) && (div_next == '0) && (bit_next == LAST_STOP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            div_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            txd_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            txd_reg   <= txd_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign fifo_pop = pop & reset;
    assign txd      = txd_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: each frame is compared cycle by cycle
// against the ideal bit sequence derived from the word.
module tb_fifo_uart_tx;

    localparam int WIDTH        = 8;
    localparam int CLKS_PER_BIT = 4;
    localparam int STOP_BITS    = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME = (1 + WIDTH + PBITS + STOP_BITS) * CLKS_PER_BIT;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] fifo_q;
    logic             fifo_ready;
    logic             fifo_pop;
    logic             cts;
    logic             txd;
    logic             busy;
    logic             done;

    int total_checks  = 0;
    int passed_checks = 0;

    fifo_uart_tx #(
        .WIDTH        (WIDTH),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .STOP_BITS    (STOP_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_q     (fifo_q),
        .fifo_ready (fifo_ready),
        .fifo_pop   (fifo_pop),
        .cts        (cts),
        .txd        (txd),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal line level in frame cycle c (1-based, cycle after the pop edge is 1).
    function automatic logic exp_txd(input logic [WIDTH-1:0] w, input int c);
        int idx;
        idx = (c - 1) / CLKS_PER_BIT;
        if (idx == 0)
            return 1'b0;
        if (idx <= WIDTH)
            return w[idx-1];
        if (PBITS == 1 && idx == WIDTH + 1)
            return ^w;
        return 1'b1;
    endfunction

    // Called at the negedge where a pop is expected. Checks the whole frame and the
    // following IDLE cycle; returns early at negedge abort_at (0 = never).
    task automatic run_frame(input logic [WIDTH-1:0] w, input bit keep_ready,
                             input int cts_drop, input int abort_at);
        logic exp_done;
        #1;
        total_checks++;
        if (fifo_pop !== 1'b1)
            $display("FAIL pop_start: fifo_pop=%b required 1 (word %h)", fifo_pop, w);
        else
            passed_checks++;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            if (c == abort_at)
                return;
            exp_done = (c == FRAME);
            total_checks++;
            if (txd !== exp_txd(w, c))
                $display("FAIL frame_txd: word %h cycle %0d txd=%b required %b", w, c, txd, exp_txd(w, c));
            else
                passed_checks++;
            total_checks++;
            if (busy !== 1'b1)
                $display("FAIL frame_busy: word %h cycle %0d busy=%b required 1", w, c, busy);
            else
                passed_checks++;
            total_checks++;
            if (done !== exp_done)
                $display("FAIL frame_done: word %h cycle %0d done=%b required %b", w, c, done, exp_done);
            else
                passed_checks++;
            total_checks++;
            if (fifo_pop !== 1'b0)
                $display("FAIL frame_pop: word %h cycle %0d fifo_pop=%b required 0", w, c, fifo_pop);
            else
                passed_checks++;
            if (!keep_ready)
                fifo_ready = 1'b0;
            fifo_q = WIDTH'($urandom);
            if (c == cts_drop)
                cts = 1'b0;
        end
        @(negedge clk);
        total_checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_gap: txd=%b busy=%b done=%b required 1 0 0", txd, busy, done);
        else
            passed_checks++;
        total_checks++;
        if (fifo_pop !== (fifo_ready & cts))
            $display("FAIL idle_pop: fifo_pop=%b required %b", fifo_pop, fifo_ready & cts);
        else
            passed_checks++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total_checks++;
            if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || fifo_pop !== 1'b0)
                $display("FAIL reset_state: txd=%b busy=%b done=%b pop=%b required 1 0 0 0",
                         txd, busy, done, fifo_pop);
            else
                passed_checks++;
        end
        fifo_ready = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        total_checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0)
            $display("FAIL reset_release: txd=%b busy=%b pop=%b required 1 0 0", txd, busy, fifo_pop);
        else
            passed_checks++;
    endtask

    task automatic test_single();
        @(negedge clk);
        fifo_q     = 8'hA5;
        fifo_ready = 1'b1;
        cts        = 1'b1;
        run_frame(8'hA5, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        fifo_q     = 8'h00;
        fifo_ready = 1'b1;
        cts        = 1'b1;
        run_frame(8'h00, 1'b1, 0, 0);
        fifo_q = 8'hFF;
        run_frame(8'hFF, 1'b0, 0, 0);
    endtask

    task automatic test_flow_control();
        logic [WIDTH-1:0] w;
        @(negedge clk);
        fifo_ready = 1'b1;
        cts        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            total_checks++;
            if (fifo_pop !== 1'b0 || txd !== 1'b1 || busy !== 1'b0)
                $display("FAIL cts_hold: cycle %0d pop=%b txd=%b busy=%b required 0 1 0",
                         i, fifo_pop, txd, busy);
            else
                passed_checks++;
            @(negedge clk);
        end
        w      = WIDTH'($urandom);
        fifo_q = w;
        cts    = 1'b1;
        // data bit 2 occupies frame cycles 13..16
        run_frame(w, 1'b0, 13, 0);
        cts = 1'b1;
    endtask

    task automatic test_random_frames();
        logic [WIDTH-1:0] w;
        int gap;
        int sel;
        for (int n = 0; n < 12; n++) begin
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                sel = $urandom_range(0, 2);
                fifo_ready = (sel == 1);
                cts        = (sel == 0);
                fifo_q     = WIDTH'($urandom);
                #1;
                total_checks++;
                if (fifo_pop !== 1'b0 || txd !== 1'b1 || busy !== 1'b0)
                    $display("FAIL rand_gap: pop=%b txd=%b busy=%b required 0 1 0", fifo_pop, txd, busy);
                else
                    passed_checks++;
            end
            @(negedge clk);
            w          = WIDTH'($urandom);
            fifo_q     = w;
            fifo_ready = 1'b1;
            cts        = 1'b1;
            run_frame(w, 1'b0, $urandom_range(0, FRAME), 0);
            cts = 1'b1;
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        fifo_q     = 8'h3C;
        fifo_ready = 1'b1;
        cts        = 1'b1;
        // data bit 3 occupies frame cycles 17..20
        run_frame(8'h3C, 1'b0, 0, 18);
        fifo_ready = 1'b1;
        reset      = 1'b0;
        #1;
        total_checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || fifo_pop !== 1'b0)
            $display("FAIL reset_mid: txd=%b busy=%b done=%b pop=%b required 1 0 0 0",
                     txd, busy, done, fifo_pop);
        else
            passed_checks++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_checks++;
            if (txd !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0)
                $display("FAIL reset_hold: txd=%b busy=%b pop=%b required 1 0 0", txd, busy, fifo_pop);
            else
                passed_checks++;
        end
        fifo_ready = 1'b0;
        reset      = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total_checks++;
            if (txd !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0)
                $display("FAIL after_reset: cycle %0d txd=%b busy=%b pop=%b required 1 0 0",
                         i, txd, busy, fifo_pop);
            else
                passed_checks++;
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        @(negedge clk);
        fifo_q     = 8'h07;
        fifo_ready = 1'b1;
        cts        = 1'b1;
        run_frame(8'h07, 1'b0, 0, 0);
        @(negedge clk);
        fifo_q     = 8'h03;
        fifo_ready = 1'b1;
        run_frame(8'h03, 1'b0, 0, 0);
    endtask
`endif

    initial begin
        reset      = 1'b0;
        fifo_ready = 1'b1;
        cts        = 1'b1;
        fifo_q     = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_flow_control();
        test_random_frames();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
